// File: rtl/axi_read_error_responder_if.sv
// Decode-error read responder bundle: AR capture side from the address
// decoder plus the R channel returned toward the requesting master.
//
// R handshake: a beat transfers on a rising clk edge where rvalid_o and
// rready_i are both high. Once rvalid_o rises it stays high, and rid_o,
// rdata_o, rresp_o, rlast_o and ruser_o hold their values, until that
// transfer occurs. rready_i may change freely.
interface axi_read_error_responder_if #(
    parameter int ID_WIDTH   = 6,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6
);
    logic                  sample_ardata_info_i;
    logic [ID_WIDTH-1:0]   arid_i;
    logic [7:0]            arlen_i;
    logic [USER_WIDTH-1:0] aruser_i;
    logic                  outstanding_trans_i;
    logic                  error_gnt_o;
    logic                  rvalid_o;
    logic                  rready_i;
    logic [ID_WIDTH-1:0]   rid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic [1:0]            rresp_o;
    logic                  rlast_o;
    logic [USER_WIDTH-1:0] ruser_o;
    logic                  busy_o;
    // Debug visibility: FSM state, beat counter, ignored-sample pulse.
    logic [1:0]            state_dbg;
    logic [7:0]            beat_cnt_dbg;
    logic                  resample_err;

    modport slave (
        input  sample_ardata_info_i, arid_i, arlen_i, aruser_i,
        input  outstanding_trans_i, rready_i,
        output error_gnt_o, rvalid_o, rid_o, rdata_o, rresp_o, rlast_o,
        output ruser_o, busy_o, state_dbg, beat_cnt_dbg, resample_err
    );

    modport master (
        output sample_ardata_info_i, arid_i, arlen_i, aruser_i,
        output outstanding_trans_i, rready_i,
        input  error_gnt_o, rvalid_o, rid_o, rdata_o, rresp_o, rlast_o,
        input  ruser_o, busy_o, state_dbg, beat_cnt_dbg, resample_err
    );
endinterface

// File: rtl/axi_read_error_responder.sv
// Returns ARLEN+1 DECERR beats for a read the decoder could not route,
// after earlier legitimate reads have drained, then grants the decoder
// back out of its ERROR state.
module axi_read_error_responder #(
    parameter int ID_WIDTH   = 6,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = {DATA_WIDTH/32{32'hBADCAB1E}}
) (
    input logic clk,
    input logic rst_n,
    axi_read_error_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic [USER_WIDTH-1:0] user_q;
    logic [7:0]            beat_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic                  gnt_q;
    logic                  resample_q;

    // Capture, drain wait, beat generation and grant, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            id_q       <= '0;
            len_q      <= '0;
            user_q     <= '0;
            beat_cnt   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            gnt_q      <= 1'b0;
            resample_q <= 1'b0;
        end else begin
            // A sample while busy means the decoder left ERROR early; it is
            // ignored here and only reported.
            resample_q <= bus.sample_ardata_info_i && (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.sample_ardata_info_i) begin
                        id_q     <= bus.arid_i;
                        len_q    <= bus.arlen_i;
                        user_q   <= bus.aruser_i;
                        beat_cnt <= 8'd0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.outstanding_trans_i) begin
                        state    <= SEND;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (beat_cnt == len_q);
                        rdata_q  <= ERR_DATA;
                    end
                end
                SEND: begin
                    if (bus.rready_i) begin
                        if (rlast_q) begin
                            state    <= DONE;
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            gnt_q    <= 1'b1;
                        end else begin
                            // Never reached with beat_cnt at 255: that beat is always last.
                            beat_cnt <= beat_cnt + 8'd1;
                            rlast_q  <= ((beat_cnt + 8'd1) == len_q);
                        end
                    end
                end
                DONE: begin
                    gnt_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rvalid_o     = rvalid_q;
    assign bus.rlast_o      = rlast_q;
    assign bus.rid_o        = id_q;
    assign bus.ruser_o      = user_q;
    assign bus.rdata_o      = rdata_q;
    assign bus.rresp_o      = 2'b11;
    assign bus.error_gnt_o  = gnt_q;
    assign bus.busy_o       = (state != IDLE);
    assign bus.state_dbg    = state;
    assign bus.beat_cnt_dbg = beat_cnt;
    assign bus.resample_err = resample_q;

    resample_while_busy : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(bus.sample_ardata_info_i && (state != IDLE))
    ) else $warning("sample_ardata_info_i asserted while responder busy; ignored");

endmodule
